// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and the ALU
// opcode bit positions that select signed/unsigned and quotient/remainder.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // alu_op layout for the DIV/MOD group: bit0 = MOD, bit1 = unsigned (.WU)
  localparam int unsigned ALU_OP_W       = 4;
  localparam int unsigned ALU_OP_REM_BIT = 0;
  localparam int unsigned ALU_OP_UNS_BIT = 1;

  function automatic logic op_is_signed(input logic [ALU_OP_W-1:0] op);
    return ~op[ALU_OP_UNS_BIT];
  endfunction

  function automatic logic op_is_rem(input logic [ALU_OP_W-1:0] op);
    return op[ALU_OP_REM_BIT];
  endfunction

endpackage

// File: rtl/iter_div_unit_if.sv
// Request/response bundle between the EXE stage (master) and the divider (slave).
interface iter_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic             in_rem;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;

  modport master (
    output in_valid, in_signed, in_rem, in_src1, in_src2, flush, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_signed, in_rem, in_src1, in_src2, flush, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/div_iter_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial
// subtract the divisor, keep the difference if it did not go negative.
module div_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             quo_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {2'b00, divisor};
    quo_bit = ~diff[WIDTH+1];
    rem_out = quo_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle DIV/MOD unit: magnitudes are divided one quotient bit per cycle,
// signs and the divide-by-zero result are applied when entering DONE.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  iter_div_unit_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d, rsel_q, rsel_d;
  logic             neg1_q, neg1_d, neg2_q, neg2_d, dz_q, dz_d;
  logic             in_ready_q, out_valid_q;
  logic             accept_c;
  logic [WIDTH:0]   step_rem_c;
  logic             step_bit_c;
  logic [WIDTH-1:0] quo_fin_c;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return {WIDTH{1'b0}} - x;
  endfunction

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (quo_q[WIDTH-1]),
    .divisor      (dvsr_q),
    .rem_out      (step_rem_c),
    .quo_bit      (step_bit_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    src1_d    = src1_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    rsel_d    = rsel_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    dz_d      = dz_q;
    accept_c  = bus.in_valid & in_ready_q & ~bus.flush;
    quo_fin_c = {quo_q[WIDTH-2:0], step_bit_c};

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          sgn_d   = bus.in_signed;
          rsel_d  = bus.in_rem;
          neg1_d  = bus.in_signed & bus.in_src1[WIDTH-1];
          neg2_d  = bus.in_signed & bus.in_src2[WIDTH-1];
          quo_d   = neg1_d ? negate(bus.in_src1) : bus.in_src1;
          dvsr_d  = neg2_d ? negate(bus.in_src2) : bus.in_src2;
          src1_d  = bus.in_src1;
          dz_d    = (bus.in_src2 == {WIDTH{1'b0}});
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = step_rem_c;
        quo_d = quo_fin_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          // Remainder sign follows the dividend; divide-by-zero overrides both
          if (dz_q)
            result_d = rsel_q ? src1_q : {WIDTH{1'b1}};
          else if (rsel_q)
            result_d = (sgn_q & neg1_q) ? negate(step_rem_c[WIDTH-1:0])
                                        : step_rem_c[WIDTH-1:0];
          else
            result_d = (sgn_q & (neg1_q ^ neg2_q)) ? negate(quo_fin_c) : quo_fin_c;
        end
      end
      S_DONE: begin
        if (out_valid_q & bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) state_d = S_IDLE;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      src1_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      rsel_q      <= 1'b0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      src1_q      <= src1_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      rsel_q      <= rsel_d;
      neg1_q      <= neg1_d;
      neg2_q      <= neg2_d;
      dz_q        <= dz_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Randomised and directed checks of iter_div_unit (WIDTH=32) against an
// arithmetic reference model of DIV/DIVU/MOD/MODU semantics.
module tb_iter_div_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_pass   = 0;

  iter_div_unit_if #(.WIDTH(W)) bus ();

  iter_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: truncating division, remainder follows dividend, x/0 = all ones rem x
  function automatic logic [31:0] model(input bit sgn, input bit rem,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    return rem ? r[31:0] : q[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in the current cycle; returns one cycle later
  task automatic launch(input bit sgn, input bit rem, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid  = 1'b1;
    bus.in_signed = sgn;
    bus.in_rem    = rem;
    bus.in_src1   = a;
    bus.in_src2   = b;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'($urandom);
    bus.in_rem    = 1'($urandom);
    bus.in_src1   = $urandom;
    bus.in_src2   = $urandom;
  endtask

  // Wait for out_valid with a bound; check latency, busy in_ready, and result
  task automatic wait_result(input string tag, input logic [31:0] exp);
    int lat = 1;
    bit busy_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, LAT);
    check_eq({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check_eq({tag, "_result"}, bus.out_result, exp);
  endtask

  // Hold off the consumer for 'stall' cycles, then complete the handshake
  task automatic drain(input string tag, input int stall, input logic [31:0] exp);
    bit stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!bus.out_valid || bus.out_result !== exp || bus.in_ready) stable = 1'b0;
    end
    if (stall > 0) check_eq({tag, "_stall"}, 32'(stable), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic do_op(input string tag, input bit sgn, input bit rem,
                       input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] exp;
    exp = model(sgn, rem, a, b);
    check_eq({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    launch(sgn, rem, a, b);
    wait_result(tag, exp);
    drain(tag, stall, exp);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check_eq({tag, "_no_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_rem    = 1'b0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    resetn        = 1'b0;
    tick();
    tick();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_result", bus.out_result, 32'd0);
    resetn = 1'b1;
    tick();

    // Directed cases from the plan
    do_op("udiv", 0, 0, 32'd100, 32'd7, 0);
    do_op("umod", 0, 1, 32'd100, 32'd7, 0);
    do_op("sdiv_n7_2", 1, 0, -32'sd7, 32'd2, 1);
    do_op("smod_n7_2", 1, 1, -32'sd7, 32'd2, 0);
    do_op("sdiv_7_n2", 1, 0, 32'd7, -32'sd2, 0);
    do_op("smod_7_n2", 1, 1, 32'd7, -32'sd2, 2);
    do_op("sovf_div", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("sovf_mod", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("uovf_div", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("uovf_mod", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("udz_div", 0, 0, 32'h1234_5678, 32'd0, 0);
    do_op("udz_mod", 0, 1, 32'h1234_5678, 32'd0, 0);
    do_op("sdz_div", 1, 0, 32'h1234_5678, 32'd0, 0);
    do_op("sdz_mod", 1, 1, 32'h1234_5678, 32'd0, 0);
    do_op("bp5", 0, 0, 32'd100, 32'd7, 5);

    // Flush at iteration 10 cancels the operation
    launch(0, 0, 32'd100, 32'd7);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("flush_calc_ready", 32'(bus.in_ready), 32'd1);
    check_eq("flush_calc_valid", 32'(bus.out_valid), 32'd0);
    watch_quiet("flush_calc", 40);
    do_op("after_flush", 0, 0, 32'd9, 32'd3, 0);

    // Reset mid-calculation clears everything including out_result
    launch(1, 0, 32'd1000, 32'd3);
    repeat (9) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_eq("rstmid_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rstmid_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rstmid_result", bus.out_result, 32'd0);
    watch_quiet("rstmid", 40);
    do_op("after_rst", 0, 0, 32'd9, 32'd3, 0);

    // Flush coincident with a request: not accepted
    bus.in_valid  = 1'b1;
    bus.in_src1   = 32'd50;
    bus.in_src2   = 32'd5;
    bus.flush     = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    check_eq("flush_req_ready", 32'(bus.in_ready), 32'd1);
    watch_quiet("flush_req", 40);

    // Flush while a result is pending discards it
    launch(0, 0, 32'd77, 32'd7);
    wait_result("flush_done", 32'd11);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("flush_done_ready", 32'(bus.in_ready), 32'd1);
    check_eq("flush_done_valid", 32'(bus.out_valid), 32'd0);

    // Flush coincident with the output handshake
    launch(0, 1, 32'd77, 32'd10);
    wait_result("flush_hs", 32'd7);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("flush_hs_ready", 32'(bus.in_ready), 32'd1);
    check_eq("flush_hs_valid", 32'(bus.out_valid), 32'd0);

    // Random operands with a bias toward edge values
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), a, b,
            int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iter_div_unit.md
# iter_div_unit

Parametrised multi-cycle integer divider that replaces the fixed-latency divider IP in the EXE-stage ALU. It implements DIV.W/DIV.WU/MOD.W/MOD.WU semantics for any operand width. A radix-2 restoring iteration produces one quotient bit per cycle, with a valid/ready handshake on both sides and a pipeline flush input for exception/branch cancellation. The EXE stage holds the instruction while `in_ready` or `out_valid` is low.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; legal values are WIDTH ≥ 2.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: sole clock; all state updates on the rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request (IDLE state).
- `in_signed` input 1: 1 = two's-complement operands, 0 = unsigned.
- `in_rem` input 1: 1 = return remainder (MOD), 0 = return quotient (DIV).
- `in_src1` input WIDTH: dividend.
- `in_src2` input WIDTH: divisor.
- `flush` input 1: cancel any in-flight or completed-but-unconsumed operation.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `out_result` output WIDTH: quotient or remainder, as selected by the captured `in_rem`.

## Operation
- **FSM states:** IDLE, CALC, DONE. Reset state is IDLE.
- **Accept:** `accept = in_valid & in_ready & ~flush`.
  - On accept, capture `in_signed` and `in_rem`.
  - Capture the sign of each operand (only when `in_signed` is set).
  - Capture |src1| and |src2| as WIDTH-bit unsigned magnitudes.
  - Set the divisor-zero flag.
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter (`$clog2(WIDTH+1)` bits).
  - Go to CALC.
- **CALC, once per cycle:**
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, commit it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Increment the counter. After WIDTH iterations, go to DONE.
- **Entering DONE, sign fix-up:**
  - The quotient is negated iff `signed & (sign1 ^ sign2)`.
  - The remainder is negated iff `signed & sign1`, so the remainder sign follows the dividend.
- **Divide by zero** (unsigned and signed): quotient = all ones; remainder = original `in_src1`. These override the fix-up.
- **Signed overflow** (MIN / −1): quotient = MIN, remainder = 0. The natural result of the algorithm already gives this; no special case is needed.
- **DONE:** hold `out_valid` high and `out_result` stable until `out_valid & out_ready`, then go to IDLE.
- **Flush:** takes priority over every transition except reset. It forces IDLE on the next edge. No result is emitted, and any pending DONE result is discarded.

## Timing
- **Reset values:** state = IDLE, `in_ready` = 1 (decoded from state), `out_valid` = 0, `out_result` = 0, counter = 0.
- **Latency:** accept in cycle T → `out_valid` first high in cycle T+WIDTH+1. This is fixed for all operands, including divide-by-zero.
- **Throughput:** `in_ready` is low from T+1 until the cycle after the output handshake. There is no overlap; the earliest next accept is the cycle after the handshake.
- **Handshake stability:**
  - `out_result` and `out_valid` must not change while `out_valid & ~out_ready`.
  - Inputs are sampled only in the accept cycle.
- **Flush timing:**
  - Flush in any cycle → `in_ready` = 1 and `out_valid` = 0 in the next cycle.
  - Flush coincident with `in_valid` → the request is not accepted.
  - Flush coincident with an output handshake → the handshake completes and the state still returns to IDLE.
- **Reset mid-operation** behaves like flush and also clears `out_result`.

## Structure
- Shared package `div_pkg` holds:
  - FSM state encoding (IDLE/CALC/DONE).
  - Opcode bit positions mapping the ALU `alu_op` DIV/MOD bits to `in_signed`/`in_rem`, for reuse by the ALU decoder.
- One natural sub-module, `div_iter_step`: purely combinational, one restoring step. It takes partial remainder, dividend bits, and divisor, and returns the next remainder and quotient bit. This lets a later radix-4 version instantiate it twice per cycle.

## Test plan
All scenarios use WIDTH = 32.
- **Unsigned divide:** 100 / 7 → quotient 0x0000000E, remainder 0x00000002. `out_valid` rises exactly 33 cycles after accept.
- **Signed sign rules:**
  - −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0x00000000. The same operands unsigned → quotient 0x00000000, remainder 0x80000000.
- **Divide by zero:** 0x12345678 / 0, both signed and unsigned → quotient 0xFFFFFFFF, remainder 0x12345678, with latency still 33 cycles.
- **Backpressure:** hold `out_ready` low for 5 cycles in DONE → `out_valid`/`out_result` stable and `in_ready` low. The handshake on cycle 6 is followed by `in_ready` = 1 in the next cycle.
- **Flush/reset mid-CALC:**
  - Flush at iteration 10 → next cycle `in_ready` = 1, and `out_valid` never asserts for that operation.
  - A following 9 / 3 returns 3.
  - Repeat with `resetn` low in place of flush → all outputs return to their reset values.
